// File: rtl/datapath_ctrl.sv
// +----------------------------------------------------------------------------+
// | datapath_ctrl: start/valid-ready sequencer driving the 4-operand datapath.  |
// | Optional abort-on-idle timeout: define DATAPATH_CTRL_TIMEOUT_EN.            |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module datapath_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] capture,
  output logic       op,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_A = 3'd1,
    LD_B = 3'd2,
    LD_C = 3'd3,
    LD_D = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_op_count;
  logic       w_in_ld;
  logic       w_abort;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("datapath_ctrl: TIMEOUT_CYCLES out of range 1..65535");
    end
  endgenerate

  assign w_in_ld = (r_state == LD_A) || (r_state == LD_B) ||
                   (r_state == LD_C) || (r_state == LD_D);

`ifdef DATAPATH_CTRL_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;

  // Counter runs only on stall cycles; any accepted word or non-load state clears it.
  assign w_abort = w_in_ld && !in_valid && (r_wait_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_wait_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_abort;
      if (w_in_ld && !in_valid)
        r_wait_cnt <= r_wait_cnt + 16'd1;
      else
        r_wait_cnt <= 16'd0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op_count <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == RESP)
        r_op_count <= r_op_count + 8'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = w_in_ld;
    capture      = 3'b000;
    op           = 1'b0;
    busy         = (r_state != IDLE);
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = LD_A;
      LD_A: begin
        capture[0] = in_valid;
        if (in_valid)     w_state_next = LD_B;
        else if (w_abort) w_state_next = IDLE;
      end
      LD_B: begin
        capture[1] = in_valid;
        if (in_valid)     w_state_next = LD_C;
        else if (w_abort) w_state_next = IDLE;
      end
      LD_C: begin
        capture[2] = in_valid;
        if (in_valid)     w_state_next = LD_D;
        else if (w_abort) w_state_next = IDLE;
      end
      LD_D: begin
        op = in_valid;
        if (in_valid)     w_state_next = RESP;
        else if (w_abort) w_state_next = IDLE;
      end
      RESP: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign op_count = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_datapath_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_datapath_ctrl: scoreboard bench for datapath_ctrl with a datapath model. |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_datapath_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] d_in;
  logic       in_ready;
  logic [2:0] capture;
  logic       op;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [7:0] op_count;

  datapath_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .capture     (capture),
    .op          (op),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .op_count    (op_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference datapath: result = (A+B)-(C+D) mod 32, loaded by the DUT strobes.
  logic [3:0] reg_a, reg_b, reg_c;
  logic [4:0] result;
  always @(posedge clock) begin
    if (!rst_n) begin
      reg_a <= '0; reg_b <= '0; reg_c <= '0; result <= '0;
    end else begin
      if (capture[0]) reg_a <= d_in;
      if (capture[1]) reg_b <= d_in;
      if (capture[2]) reg_c <= d_in;
      if (op) result <= (5'(reg_a) + 5'(reg_b)) - (5'(reg_c) + 5'(d_in));
    end
  end

  typedef struct {
    int res;
    int scyc;
    int lat;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: every done pulse is matched against the oldest expected operation.
  bit prev_done = 1'b0;
  always @(negedge clock) begin
    if (done) begin
      if (prev_done) begin
        chk("done_width", int'(done), 0);
      end else if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(result), e.res);
        chk("latency", cyc - e.scyc, e.lat);
        chk("op_count_at_done", int'(op_count), e.cnt);
      end
    end
    prev_done = done;
  end

  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d,
                       input int stall_b, input bit start_resp, input int exp_res);
    logic [3:0] w[4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    @(negedge clock);
    start = 1'b1;
    sb.push_back('{exp_res, cyc, 5 + stall_b, exp_cnt});
    exp_cnt = (exp_cnt + 1) % 256;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        for (int s = 0; s < stall_b; s++) begin
          in_valid = 1'b0;
          start    = 1'b1;
          #1;
          chk("stall_capture", int'(capture), 0);
          chk("stall_busy", int'(busy), 1);
          @(negedge clock);
        end
        start = 1'b0;
      end
      in_valid = 1'b1;
      d_in     = w[i];
      #1;
      if (i < 3) begin
        chk("capture", int'(capture), 1 << i);
        chk("op_low", int'(op), 0);
      end else begin
        chk("capture_at_op", int'(capture), 0);
        chk("op", int'(op), 1);
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    d_in     = 4'd0;
    if (start_resp) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      #1;
      chk("resp_start_ignored", int'(busy), 0);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_capture"}, int'(capture), 0);
    chk({tag, "_op"}, int'(op), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_op_count"}, int'(op_count), exp_cnt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; d_in = 4'd0;
    repeat (3) @(negedge clock);
    #1 chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Reset while in LD_C: sequence abandoned, no done.
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; in_valid = 1'b1; d_in = 4'd1;
    @(negedge clock); d_in = 4'd2;
    @(negedge clock); in_valid = 1'b0;
    #1 chk("ld_c_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clock); in_valid = 1'b1;
    #1 chk_idle_outputs("midreset");
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    #1 chk("post_reset_busy", int'(busy), 0);

    do_op(4'd5, 4'd3, 4'd2, 4'd1, 0, 1'b0, 5);
    do_op(4'd0, 4'd0, 4'd15, 4'd15, 0, 1'b0, 2);
    do_op(4'd7, 4'd9, 4'd4, 4'd6, 3, 1'b1, 6);
    @(negedge clock);
    #1 chk("op_count_after3", int'(op_count), 3);

    // Stall after A indefinitely.
    start = 1'b1;
    @(negedge clock); start = 1'b0; in_valid = 1'b1; d_in = 4'd9;
    @(negedge clock); in_valid = 1'b0;
`ifdef DATAPATH_CTRL_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        @(negedge clock);
        #1;
        if (timeout_err) begin
          seen = 1'b1;
          chk("timeout_busy", int'(busy), 0);
        end
      end
      chk("timeout_seen", int'(seen), 1);
      @(negedge clock);
      #1 chk("timeout_width", int'(timeout_err), 0);
      chk("timeout_op_count", int'(op_count), exp_cnt);
    end
`else
    repeat (20) @(negedge clock);
    #1 chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_err", int'(timeout_err), 0);
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    exp_cnt = 0;
`endif

    for (int i = 0; i < 256; i++) begin
      int a, b, c, d;
      a = i % 16; b = (i * 3) % 16; c = (i * 5) % 16; d = (i * 7) % 16;
      do_op(4'(a), 4'(b), 4'(c), 4'(d), 0, 1'b0, (a + b - c - d) & 31);
    end
    repeat (2) @(negedge clock);
    #1 chk("final_op_count", int'(op_count), exp_cnt);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
